// File: rtl/matrix_pkg.sv
// matrix_pkg: shared command encodings, FSM states and default geometry for the LED frame writer
package matrix_pkg;
  localparam int DEF_ROWS = 8;
  localparam int DEF_COLS = 8;
  localparam logic [1:0] OP_PIX_SET    = 2'd0;
  localparam logic [1:0] OP_PIX_CLR    = 2'd1;
  localparam logic [1:0] OP_FILL_CLEAR = 2'd2;
  localparam logic [1:0] OP_COMMIT     = 2'd3;
  typedef enum logic [1:0] {IDLE, CLEAR, WAIT_SWAP} state_t;
endpackage

// File: rtl/matrix_frame_writer.sv
// matrix_frame_writer: builds LED frames from commands and swaps them out at the scanner frame boundary
// DOUBLE_BUFFER_EN: when defined, draws into a back buffer; otherwise draws straight into matrix
module matrix_frame_writer
  import matrix_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [$clog2(COLS)-1:0]  cmd_x,
  input  logic [$clog2(ROWS)-1:0]  cmd_y,
  input  logic [ROWS-1:0]          scan_row,
  output logic [ROWS*COLS-1:0]     matrix,
  output logic                     frame_done
);
  localparam int N = ROWS * COLS;
  localparam int IW = $clog2(N);
  localparam int YW = $clog2(ROWS);
  localparam logic [ROWS-1:0] LAST = ROWS'(1) << (ROWS - 1);
  state_t state, state_next;
  logic [YW-1:0] rc, rc_next;
  logic [N-1:0] draw, draw_next;
  logic [IW-1:0] idx;
  logic in_range, swap;
`ifdef DOUBLE_BUFFER_EN
  logic [N-1:0] front;
  assign matrix = front;
`else
  assign matrix = draw;
`endif
  assign in_range = int'(cmd_x) < COLS && int'(cmd_y) < ROWS;
  assign idx = IW'(int'(cmd_y) * COLS + int'(cmd_x));
  always_comb begin
    state_next = state;
    rc_next = rc;
    draw_next = draw;
    swap = 1'b0;
    cmd_ready = state == IDLE;
    case (state)
      IDLE: if (cmd_valid) begin
        if ((cmd_op == OP_PIX_SET || cmd_op == OP_PIX_CLR) && in_range) draw_next[idx] = cmd_op == OP_PIX_SET;
        if (cmd_op == OP_FILL_CLEAR) begin
          state_next = CLEAR;
          rc_next = '0;
        end
        if (cmd_op == OP_COMMIT) state_next = WAIT_SWAP;
      end
      CLEAR: begin
        for (int r = 0; r < ROWS; r++) if (rc == YW'(r)) draw_next[COLS*r +: COLS] = '0;
        rc_next = rc == YW'(ROWS - 1) ? '0 : rc + 1'b1;
        state_next = rc == YW'(ROWS - 1) ? IDLE : CLEAR;
      end
      // only a clean one-hot last row counts as the frame boundary
      WAIT_SWAP: if (scan_row == LAST) begin
        swap = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      rc <= '0;
      draw <= '0;
      frame_done <= 1'b0;
`ifdef DOUBLE_BUFFER_EN
      front <= '0;
`endif
    end else begin
      state <= state_next;
      rc <= rc_next;
      draw <= draw_next;
      frame_done <= swap;
`ifdef DOUBLE_BUFFER_EN
      front <= swap ? draw : front;
`endif
    end
endmodule
